chan_arb_mux: RTL and testbench
===============================

# chan_arb_mux

Parametrised N-channel stream multiplexer with valid/ready handshakes, a registered output stage, and two selection modes: fixed select (explicit `sel`) and round-robin arbitration among valid channels. It replaces hard-wired combinational 4:1 operand muxes in the factorization datapath wherever several producers feed one consumer. It sustains one beat per cycle without losing or duplicating data under backpressure.

## Interface
- `WIDTH`, 8: data width per channel.
- `NUM_CH`, 4: number of input channels, ≥ 2.
- `SEL_W`, `$clog2(NUM_CH)`: width of `sel` and `y_ch`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mode`  in  1  selection mode: 0 = fixed select, 1 = round-robin.
- `sel`  in  SEL_W  channel index used in mode 0.
- `x`  in  NUM_CH*WIDTH  packed channel data; channel i is `x[i*WIDTH +: WIDTH]`.
- `in_valid`  in  NUM_CH  per-channel valid.
- `in_last`  in  NUM_CH  per-channel end-of-packet marker.
- `in_ready`  out  NUM_CH  per-channel ready; at most one bit set.
- `y`  out  WIDTH  output data, registered.
- `y_valid`  out  1  output valid, registered.
- `y_last`  out  1  `in_last` of the transferred beat, registered.
- `y_ch`  out  SEL_W  source channel of the current output beat, registered.
- `y_ready`  in  1  consumer ready.

## Operation
- Grant `g` is computed combinationally each cycle.
  - Mode 0: `g = sel` if `sel < NUM_CH` and `in_valid[sel]`; otherwise no grant.
  - Mode 1: `g` is the first channel with `in_valid` set, searching upward from `rr_ptr` with wrap-around. No valid channel means no grant.
- `can_load = !y_valid || y_ready`.
- `in_ready[g] = can_load` when a grant exists; all other bits are 0. All bits are forced to 0 while `rst_n` is low.
- A transfer occurs on channel g when `in_valid[g] && in_ready[g]`. At that clock edge the output registers load: `y`←x[g], `y_last`←`in_last[g]`, `y_ch`←g, `y_valid`←1.
- If `y_valid && y_ready` and there is no transfer, `y_valid`←0. `y`, `y_last` and `y_ch` hold their values.
- `rr_ptr` updates only on a transfer in mode 1: `rr_ptr`←(g+1) mod NUM_CH. It is unchanged in mode 0.
- `y` holds stable while `y_valid && !y_ready`.
- A `sel` or `mode` change takes effect in the same cycle, combinationally. Beats already in the output register are unaffected.

## Timing
- Latency is 1 cycle from input transfer to `y_valid`.
- Throughput is 1 beat/cycle with `y_ready` held high.
- Reset values: `y`=0, `y_valid`=0, `y_last`=0, `y_ch`=0, `rr_ptr`=0, lock state cleared.
- Simultaneous output drain and new transfer: the register reloads and `y_valid` stays 1.
- Reset asserted mid-stream: the pending output beat is discarded and all state returns to reset values immediately.
- An input must hold `x`/`in_last` while valid and not ready; `in_valid` may drop only after a transfer (producer rule, assertion-checked in the bench).

## Configuration
- `CHMUX_LAST_LOCK_EN` defined:
  - In mode 1, after a transfer with `in_last[g]`=0, the grant locks to g. Other channels get no grant until a transfer with `in_last[g]`=1 occurs.
  - Beats from a packet are never interleaved.
  - `rr_ptr` advances only on the last beat.
  - A `mode` change to 0 clears the lock.
- Macro undefined:
  - Arbitration occurs on every beat.
  - `in_last` is passed through to `y_last` only.

## Test plan
- Mode 0, `sel`=2, `in_valid`=4'b0100, `x` ch2=0xA5, `y_ready`=1 → `in_ready`=4'b0100; next cycle `y`=0xA5, `y_valid`=1, `y_ch`=2.
- Mode 0, `sel`=1, only ch3 valid → `in_ready`=0 and `y_valid` stays 0.
- Mode 1, all channels valid continuously, `y_ready`=1 → `y_ch` sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure: `y_valid`=1 with `y`=0x11, `y_ready`=0 for 3 cycles, ch0 valid with 0x22 → `in_ready`=0 and `y`=0x11 held. On the `y_ready`=1 cycle `in_ready[0]`=1, and the next `y` is 0x22 with no gap.
- Reset mid-stream: assert `rst_n`=0 while `y_valid`=1 → `y`=0, `y_valid`=0, `in_ready`=0 immediately. After release, `rr_ptr`=0, so the first grant with all channels valid is ch0.
- With `CHMUX_LAST_LOCK_EN`, mode 1: ch1 sends 3 beats (last on beat 3) while ch2 is valid → `y_ch`=1,1,1 then 2. Without the macro, `y_ch`=1,2,…

Source files
------------

// File: rtl/chan_arb_mux.sv
// chan_arb_mux: N-channel stream mux, fixed-select (mode 0) or round-robin (mode 1) channel choice.
// Latency: 1 cycle from input transfer to y_valid; sustains 1 beat/cycle while y_ready is high.
// Backpressure: in_ready of the granted channel follows (!y_valid || y_ready); the output register holds while stalled.
//
// Ports:
//    clk, rst_n           clock (rising edge), asynchronous active-low reset
//    mode, sel            0 = fixed channel sel, 1 = round-robin among valid channels
//    x, in_valid, in_last packed per-channel data (channel i at x[i*WIDTH +: WIDTH]), valid, end-of-packet
//    in_ready             per-channel ready, one-hot or zero
//    y, y_valid, y_last   registered output beat; y_ch is its source channel
//    y_ready              consumer ready
//
// Optional feature: define CHMUX_LAST_LOCK_EN to keep packets unbroken in round-robin mode
// (the grant stays on a channel until it transfers a beat with in_last set).

module chan_arb_mux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] x,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        y,
   output logic                    y_valid,
   output logic                    y_last,
   output logic [SEL_W-1:0]        y_ch,
   input  logic                    y_ready
);

   logic [WIDTH-1:0] ch_dat [NUM_CH];
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_nxt;
   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;
   logic             can_load;
   logic             xfer;

`ifdef CHMUX_LAST_LOCK_EN
   logic             lock_vld;
   logic [SEL_W-1:0] lock_ch;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_dat[i] = x[i*WIDTH +: WIDTH];
   end

   // Grant selection. Round-robin scans upward from rr_ptr and wraps, so the
   // channel served last is the lowest priority on the next arbitration.
   always_comb begin
      logic [SEL_W-1:0] idx;
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = '0;
      if (!mode) begin
         if (int'(sel) < NUM_CH) begin
            if (in_valid[sel]) begin
               gnt_vld = 1'b1;
               gnt     = sel;
            end
         end
      end else begin
`ifdef CHMUX_LAST_LOCK_EN
         if (lock_vld) begin
            // Mid-packet: only the owning channel may be granted.
            if (in_valid[lock_ch]) begin
               gnt_vld = 1'b1;
               gnt     = lock_ch;
            end
         end else begin
`endif
            for (int k = 0; k < NUM_CH; k++) begin
               idx = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
               if (!gnt_vld && in_valid[idx]) begin
                  gnt_vld = 1'b1;
                  gnt     = idx;
               end
            end
`ifdef CHMUX_LAST_LOCK_EN
         end
`endif
      end
   end

   assign can_load = !y_valid || y_ready;
   // Reset gates ready combinationally so no producer sees a handshake while state is held clear.
   assign xfer     = rst_n && gnt_vld && can_load;
   assign in_ready = xfer ? (NUM_CH'(1) << gnt) : '0;
   assign rr_nxt   = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= '0;
         y_valid <= 1'b0;
         y_last  <= 1'b0;
         y_ch    <= '0;
      end else if (xfer) begin
         y       <= ch_dat[gnt];
         y_valid <= 1'b1;
         y_last  <= in_last[gnt];
         y_ch    <= gnt;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

`ifdef CHMUX_LAST_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         lock_vld <= 1'b0;
         lock_ch  <= '0;
      end else if (!mode) begin
         lock_vld <= 1'b0;
      end else if (xfer) begin
         lock_vld <= !in_last[gnt];
         lock_ch  <= gnt;
         // Pointer only moves at packet boundaries.
         if (in_last[gnt]) begin
            rr_ptr <= rr_nxt;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (mode && xfer) begin
         rr_ptr <= rr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_chan_arb_mux.sv
module tb_chan_arb_mux;

   localparam int W  = 8;
   localparam int NC = 4;
   localparam int SW = 2;

   typedef struct packed {
      logic [W-1:0]  d;
      logic          l;
      logic [SW-1:0] c;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [NC*W-1:0] x;
   logic [NC-1:0]   in_valid;
   logic [NC-1:0]   in_last;
   logic [NC-1:0]   in_ready;
   logic [W-1:0]    y;
   logic            y_valid;
   logic            y_last;
   logic [SW-1:0]   y_ch;
   logic            y_ready;

   int    errors = 0;
   int    checks = 0;
   beat_t sb[$];

   logic          prev_v [NC];
   logic [W-1:0]  prev_x [NC];
   logic          prev_l [NC];

   chan_arb_mux #(.WIDTH(W), .NUM_CH(NC), .SEL_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .x(x),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .y(y), .y_valid(y_valid), .y_last(y_last), .y_ch(y_ch), .y_ready(y_ready)
   );

   always #5 clk = ~clk;

   // Output scoreboard: every accepted output beat must match the oldest expected one.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && y_valid && y_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got y=%h last=%0d ch=%0d, required no beat", y, y_last, y_ch);
         end else begin
            e = sb.pop_front();
            if ({y, y_last, y_ch} !== e) begin
               errors++;
               $display("FAIL beat: got y=%h last=%0d ch=%0d, required y=%h last=%0d ch=%0d",
                        y, y_last, y_ch, e.d, e.l, e.c);
            end
         end
      end
   end

   // Producer rule: a stalled channel keeps valid, data and last until it transfers.
   initial for (int i = 0; i < NC; i++) prev_v[i] = 1'b0;
   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rst_n && prev_v[i] &&
             (!in_valid[i] || x[i*W +: W] !== prev_x[i] || in_last[i] !== prev_l[i])) begin
            checks++;
            errors++;
            $display("FAIL producer_hold ch%0d: got valid=%0d x=%h, required valid=1 x=%h",
                     i, in_valid[i], x[i*W +: W], prev_x[i]);
         end
         prev_v[i] = rst_n && in_valid[i] && !in_ready[i];
         prev_x[i] = x[i*W +: W];
         prev_l[i] = in_last[i];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [W-1:0] d, input logic l);
      x[ch*W +: W] = d;
      in_last[ch]  = l;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b1; sel = '0; x = '0; in_last = '0;
      in_valid = 4'hF; y_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready); end
      checks++; if (y !== 8'h00)         begin errors++; $display("FAIL reset_y: got %h, required 00", y); end
      checks++; if (y_valid !== 1'b0)    begin errors++; $display("FAIL reset_y_valid: got %b, required 0", y_valid); end
      checks++; if (y_last !== 1'b0)     begin errors++; $display("FAIL reset_y_last: got %b, required 0", y_last); end
      checks++; if (y_ch !== 2'd0)       begin errors++; $display("FAIL reset_y_ch: got %0d, required 0", y_ch); end
      in_valid = '0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_release_y_valid: got %b, required 0", y_valid); end
   endtask

   task automatic test_fixed_sel();
      step();
      mode = 1'b0; sel = 2'd2; set_ch(2, 8'hA5, 1'b0); in_valid = 4'b0100; y_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b, required 0100", in_ready); end
      sb.push_back('{8'hA5, 1'b0, 2'd2});
      step();
      in_valid = '0;
      @(negedge clk);
      checks++; if (y_valid !== 1'b1 || y !== 8'hA5 || y_ch !== 2'd2) begin
         errors++; $display("FAIL fixed_out: got v=%b y=%h ch=%0d, required v=1 y=a5 ch=2", y_valid, y, y_ch);
      end
      step();
      @(negedge clk);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain: got y_valid=%b, required 0", y_valid); end
   endtask

   task automatic test_fixed_no_grant();
      step();
      mode = 1'b0; sel = 2'd1; set_ch(3, 8'h3C, 1'b1); in_valid = 4'b1000; y_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++; if (in_ready !== 4'b0000 || y_valid !== 1'b0) begin
            errors++; $display("FAIL nogrant: got in_ready=%b y_valid=%b, required 0000 0", in_ready, y_valid);
         end
         step();
      end
      sel = 2'd3;
      @(negedge clk);
      checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL nogrant_sel3: got %b, required 1000", in_ready); end
      sb.push_back('{8'h3C, 1'b1, 2'd3});
      step();
      in_valid = '0;
      @(negedge clk);
      step();
   endtask

   task automatic test_round_robin();
      logic [NC-1:0] er;
      mode = 1'b1; y_ready = 1'b1;
      for (int i = 0; i < NC; i++) set_ch(i, 8'(8'h10 + i), 1'b1);
      in_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         er = 4'b0001 << (k % NC);
         checks++; if (in_ready !== er) begin errors++; $display("FAIL rr_in_ready k=%0d: got %b, required %b", k, in_ready, er); end
         sb.push_back('{8'(8'h10 + (k % NC)), 1'b1, 2'(k % NC)});
         step();
         if (k >= 4) in_valid[k % NC] = 1'b0;
      end
      @(negedge clk);
      step();
      @(negedge clk);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got y_valid=%b, required 0", y_valid); end
   endtask

   task automatic test_backpressure();
      step();
      mode = 1'b0; sel = 2'd0; set_ch(0, 8'h11, 1'b1); in_valid = 4'b0001; y_ready = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_first: got %b, required 0001", in_ready); end
      sb.push_back('{8'h11, 1'b1, 2'd0});
      step();
      set_ch(0, 8'h22, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (y_valid !== 1'b1 || y !== 8'h11 || in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold cyc%0d: got v=%b y=%h in_ready=%b, required v=1 y=11 in_ready=0000",
                               i, y_valid, y, in_ready);
         end
         step();
      end
      y_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release: got %b, required 0001", in_ready); end
      sb.push_back('{8'h22, 1'b1, 2'd0});
      step();
      in_valid = '0;
      @(negedge clk);
      checks++; if (y_valid !== 1'b1 || y !== 8'h22) begin
         errors++; $display("FAIL bp_no_gap: got v=%b y=%h, required v=1 y=22", y_valid, y);
      end
      step();
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      logic [NC-1:0] er;
      step();
      mode = 1'b1; y_ready = 1'b0;
      for (int i = 0; i < NC; i++) set_ch(i, 8'(8'h40 + i), 1'b1);
      in_valid = 4'b0010;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL mid_first: got %b, required 0010", in_ready); end
      sb.push_back('{8'h41, 1'b1, 2'd1});
      step();
      in_valid = 4'hF;
      @(negedge clk);
      checks++; if (y_valid !== 1'b1 || y !== 8'h41 || in_ready !== 4'b0000) begin
         errors++; $display("FAIL mid_stall: got v=%b y=%h in_ready=%b, required v=1 y=41 0000", y_valid, y, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 4'b0000 || y_ch !== 2'd0) begin
         errors++; $display("FAIL mid_reset: got y=%h v=%b in_ready=%b ch=%0d, required 00 0 0000 0",
                            y, y_valid, in_ready, y_ch);
      end
      sb.delete();
      step();
      rst_n = 1'b1; y_ready = 1'b1;
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         er = 4'b0001 << k;
         checks++; if (in_ready !== er) begin errors++; $display("FAIL mid_after k=%0d: got %b, required %b", k, in_ready, er); end
         sb.push_back('{8'(8'h40 + k), 1'b1, 2'(k)});
         step();
         in_valid[k] = 1'b0;
      end
      @(negedge clk);
      step();
   endtask

   task automatic test_packet_lock();
      logic [W-1:0]  bd [3];
      int            eg [4];
      int            b1;
      logic [NC-1:0] er;
      bd[0] = 8'hB1; bd[1] = 8'hB2; bd[2] = 8'hB3;
`ifdef CHMUX_LAST_LOCK_EN
      eg[0] = 1; eg[1] = 1; eg[2] = 1; eg[3] = 2;
`else
      eg[0] = 1; eg[1] = 2; eg[2] = 1; eg[3] = 1;
`endif
      b1 = 0;
      step();
      mode = 1'b1; y_ready = 1'b1;
      set_ch(1, bd[0], 1'b0); set_ch(2, 8'hC2, 1'b1);
      in_valid = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         er = 4'b0001 << eg[k];
         checks++; if (in_ready !== er) begin errors++; $display("FAIL lock k=%0d: got %b, required %b", k, in_ready, er); end
         if (eg[k] == 1) sb.push_back('{bd[b1], (b1 == 2), 2'd1});
         else            sb.push_back('{8'hC2, 1'b1, 2'd2});
         step();
         if (eg[k] == 1) begin
            b1++;
            if (b1 == 3) in_valid[1] = 1'b0;
            else         set_ch(1, bd[b1], (b1 == 2));
         end else begin
            in_valid[2] = 1'b0;
         end
      end
      @(negedge clk);
      step();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d;
      logic         xf;
      logic         done;
      int           i;
      d = 8'h60; done = 1'b0; i = 0;
      step();
      mode = 1'b0; sel = 2'd0; set_ch(0, d, d[0]); in_valid = 4'b0001; y_ready = 1'b1;
      while (!done && i < 40) begin
         @(negedge clk);
         xf = in_ready[0];
         if (xf) sb.push_back('{d, d[0], 2'd0});
         step();
         y_ready = (i >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
         if (xf) begin
            if (i >= 30) begin
               in_valid = '0;
               done = 1'b1;
            end else begin
               d = d + 8'd1;
               set_ch(0, d, d[0]);
            end
         end
         i++;
      end
      checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: got no final transfer, required one within 40 cycles"); end
      in_valid = '0; y_ready = 1'b1;
      repeat (2) begin @(negedge clk); step(); end
      @(negedge clk);
      checks++; if (y_valid !== 1'b0 || sb.size() != 0) begin
         errors++; $display("FAIL b2b_drain: got y_valid=%b pending=%0d, required 0 0", y_valid, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_fixed_sel();
      test_fixed_no_grant();
      test_round_robin();
      test_backpressure();
      test_reset_midstream();
      test_packet_lock();
      test_back_to_back();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d pending beats, required 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
